// File: rtl/pid_ctrl_param.sv
// Pipelined PID steering controller with integrator anti-windup, a configurable
// derivative look-back depth, and a forward-speed mix stage feeding the motor
// PWM drivers. Results appear two clocks after each accepted error sample.
module pid_ctrl_param #(
  parameter int ERR_W   = 11,
  parameter int P_COEFF = 2,
  parameter int D_COEFF = -8,
  parameter int D_DEPTH = 2,
  parameter int I_W     = 16,
  parameter int I_SHIFT = 4,
  parameter int SPD_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             err_vld,
  input  logic [15:0]      error,
  input  logic [10:0]      frwrd_spd,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rgt_spd,
  output logic             out_vld
);

  localparam int ERR_MAX = (2 ** (ERR_W - 1)) - 1;
  localparam int ERR_MIN = -(2 ** (ERR_W - 1));
  localparam int SPD_MAX = (2 ** (SPD_W - 1)) - 1;
  localparam int SPD_MIN = -(2 ** (SPD_W - 1));

  // Clamp the raw sensor error into the working error range
  function automatic logic signed [ERR_W-1:0] satErr(input logic signed [15:0] x);
    if (x > ERR_MAX)      return ERR_W'(ERR_MAX);
    else if (x < ERR_MIN) return ERR_W'(ERR_MIN);
    else                  return ERR_W'(x);
  endfunction

  // Clamp to the 15-bit signed range shared by the P, I and D terms
  function automatic logic signed [14:0] sat15(input int x);
    if (x > 16383)       return 15'sh3FFF;
    else if (x < -16384) return 15'sh4000;
    else                 return 15'(x);
  endfunction

  // Clamp the derivative difference to 8-bit signed before scaling
  function automatic logic signed [7:0] sat8(input int x);
    if (x > 127)       return 8'sh7F;
    else if (x < -128) return 8'sh80;
    else               return 8'(x);
  endfunction

  // Clamp a mixed motor speed to the output width
  function automatic logic signed [SPD_W-1:0] satSpd(input int x);
    if (x > SPD_MAX)      return SPD_W'(SPD_MAX);
    else if (x < SPD_MIN) return SPD_W'(SPD_MIN);
    else                  return SPD_W'(x);
  endfunction

  logic signed [ERR_W-1:0] w_errSat;
  logic signed [14:0]      w_pTerm;
  logic signed [I_W-1:0]   w_errExt;
  logic signed [I_W-1:0]   w_accSum;
  logic                    w_accOvf;
  logic signed [I_W-1:0]   w_accNext;
  logic signed [I_W-1:0]   w_iShift;
  logic signed [14:0]      w_iTerm;
  logic signed [7:0]       w_dDiff;
  logic signed [14:0]      w_dTerm;
  logic signed [14:0]      w_sum15;
  logic signed [11:0]      w_pid;
  logic signed [SPD_W-1:0] w_lft;
  logic signed [SPD_W-1:0] w_rgt;

  logic signed [I_W-1:0]   r_acc;
  logic signed [ERR_W-1:0] r_hist [D_DEPTH];
  logic signed [14:0]      r_p;
  logic signed [14:0]      r_i;
  logic signed [14:0]      r_d;
  logic                    r_v1;
  logic [SPD_W-1:0]        r_lft;
  logic [SPD_W-1:0]        r_rgt;
  logic                    r_outVld;

  assign w_errSat = satErr(error);
  assign w_pTerm  = sat15(int'(w_errSat) * P_COEFF);

  // A sum of two same-signed operands that flips sign has wrapped; hold instead
  assign w_errExt  = I_W'(w_errSat);
  assign w_accSum  = r_acc + w_errExt;
  assign w_accOvf  = (r_acc[I_W-1] == w_errExt[I_W-1]) && (w_accSum[I_W-1] != r_acc[I_W-1]);
  assign w_accNext = w_accOvf ? r_acc : w_accSum;
  assign w_iShift  = w_accNext >>> I_SHIFT;
  assign w_iTerm   = 15'(w_iShift);

  assign w_dDiff = sat8(int'(w_errSat) - int'(r_hist[D_DEPTH-1]));
  assign w_dTerm = 15'(int'(w_dDiff) * D_COEFF);

  assign w_sum15 = sat15(int'(r_p) + int'(r_i) + int'(r_d));
  assign w_pid   = 12'(w_sum15 >>> 3);
  assign w_lft   = satSpd($signed({21'b0, frwrd_spd}) + int'(w_pid));
  assign w_rgt   = satSpd($signed({21'b0, frwrd_spd}) - int'(w_pid));

  assign lft_spd = r_lft;
  assign rgt_spd = r_rgt;
  assign out_vld = r_outVld;

  // Integrator accumulates accepted samples and is emptied whenever go is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_acc <= '0;
    else if (!go)
      r_acc <= '0;
    else if (err_vld)
      r_acc <= w_accNext;
  end

  // Error history advances on every valid sample, independent of go
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D_DEPTH; k++) r_hist[k] <= '0;
    end else if (err_vld) begin
      r_hist[0] <= w_errSat;
      for (int k = 1; k < D_DEPTH; k++) r_hist[k] <= r_hist[k-1];
    end
  end

  // Stage 1 captures the three terms; only samples taken while enabled advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p  <= '0;
      r_i  <= '0;
      r_d  <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= err_vld & go;
      if (err_vld) begin
        r_p <= w_pTerm;
        r_i <= w_iTerm;
        r_d <= w_dTerm;
      end
    end
  end

  // Stage 2 mixes with forward speed; disabling zeroes speeds and drops results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft    <= '0;
      r_rgt    <= '0;
      r_outVld <= 1'b0;
    end else if (!go) begin
      r_lft    <= '0;
      r_rgt    <= '0;
      r_outVld <= 1'b0;
    end else begin
      r_outVld <= r_v1;
      if (r_v1) begin
        r_lft <= w_lft;
        r_rgt <= w_rgt;
      end
    end
  end

endmodule

// File: tb/tb_pid_ctrl_param.sv
// Testbench for pid_ctrl_param: a default build and a D_DEPTH=3 build run off
// the same stimulus, each checked against its own reference-model scoreboard.
module tb_pid_ctrl_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        err_vld;
  logic [15:0] error;
  logic [10:0] frwrd_spd;
  logic [11:0] lft_spd, rgt_spd, lft3, rgt3;
  logic        out_vld, out_vld3;

  pid_ctrl_param dut (
    .clk(clk), .rst_n(rst_n), .go(go), .err_vld(err_vld), .error(error),
    .frwrd_spd(frwrd_spd), .lft_spd(lft_spd), .rgt_spd(rgt_spd), .out_vld(out_vld)
  );

  pid_ctrl_param #(.D_DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .go(go), .err_vld(err_vld), .error(error),
    .frwrd_spd(frwrd_spd), .lft_spd(lft3), .rgt_spd(rgt3), .out_vld(out_vld3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lft;
    int rgt;
    int cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t e2, e3;
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;
  int   mAcc;
  int   mHist2[2];
  int   mHist3[3];
  int   mFwd;

  // Cycle counter used to time-stamp expected results
  always @(posedge clk) cyc++;

  function automatic int sat(input int x, input int lo, input int hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic int s12(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  task automatic modelReset();
    mAcc = 0;
    foreach (mHist2[k]) mHist2[k] = 0;
    foreach (mHist3[k]) mHist3[k] = 0;
  endtask

  task automatic modelSample(input logic [15:0] e);
    int es, sum, accN, iT, p, d, s, pid;
    exp_t x;
    es = sat(int'($signed(e)), -1024, 1023);
    if (go) begin
      sum  = mAcc + es;
      accN = (sum > 32767 || sum < -32768) ? mAcc : sum;
      iT   = accN >>> 4;
      p    = sat(es * 2, -16384, 16383);
      d    = sat(es - mHist2[1], -128, 127) * -8;
      s    = sat(p + iT + d, -16384, 16383);
      pid  = s >>> 3;
      x.lft = sat(mFwd + pid, -2048, 2047);
      x.rgt = sat(mFwd - pid, -2048, 2047);
      x.cyc = cyc + 2;
      q2.push_back(x);
      d    = sat(es - mHist3[2], -128, 127) * -8;
      s    = sat(p + iT + d, -16384, 16383);
      pid  = s >>> 3;
      x.lft = sat(mFwd + pid, -2048, 2047);
      x.rgt = sat(mFwd - pid, -2048, 2047);
      q3.push_back(x);
      mAcc = accN;
    end else begin
      mAcc = 0;
    end
    mHist2[1] = mHist2[0];
    mHist2[0] = es;
    mHist3[2] = mHist3[1];
    mHist3[1] = mHist3[0];
    mHist3[0] = es;
  endtask

  task automatic driveSample(input int e);
    err_vld = 1'b1;
    error   = 16'(e);
    modelSample(error);
    @(negedge clk);
    err_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    err_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clearAcc();
    go = 1'b0;
    mAcc = 0;
    @(negedge clk);
    go = 1'b1;
  endtask

  // Scoreboard: every out_vld must match the oldest expected result on time
  always @(negedge clk) begin
    if (rst_n) begin
      if (q2.size() > 0 && q2[0].cyc < cyc) begin
        nChecks++;
        $display("[TB] FAIL missing_vld2 cyc=%0d got no out_vld required one at cyc %0d", cyc, q2[0].cyc);
        q2.delete(0);
      end
      if (out_vld) begin
        nChecks++;
        if (q2.size() == 0) begin
          $display("[TB] FAIL unexpected_vld2 cyc=%0d got out_vld=1 required 0", cyc);
        end else begin
          e2 = q2.pop_front();
          if (e2.cyc !== cyc || s12(lft_spd) !== e2.lft || s12(rgt_spd) !== e2.rgt)
            $display("[TB] FAIL result2 cyc=%0d got lft=%0d rgt=%0d required lft=%0d rgt=%0d at cyc %0d",
                     cyc, s12(lft_spd), s12(rgt_spd), e2.lft, e2.rgt, e2.cyc);
          else
            nPass++;
        end
      end
      if (q3.size() > 0 && q3[0].cyc < cyc) begin
        nChecks++;
        $display("[TB] FAIL missing_vld3 cyc=%0d got no out_vld required one at cyc %0d", cyc, q3[0].cyc);
        q3.delete(0);
      end
      if (out_vld3) begin
        nChecks++;
        if (q3.size() == 0) begin
          $display("[TB] FAIL unexpected_vld3 cyc=%0d got out_vld=1 required 0", cyc);
        end else begin
          e3 = q3.pop_front();
          if (e3.cyc !== cyc || s12(lft3) !== e3.lft || s12(rgt3) !== e3.rgt)
            $display("[TB] FAIL result3 cyc=%0d got lft=%0d rgt=%0d required lft=%0d rgt=%0d at cyc %0d",
                     cyc, s12(lft3), s12(rgt3), e3.lft, e3.rgt, e3.cyc);
          else
            nPass++;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; err_vld = 1'b0; error = '0;
    frwrd_spd = 11'd512; mFwd = 512;
    modelReset();
    repeat (3) @(negedge clk);
    nChecks++;
    if (lft_spd !== 12'd0 || rgt_spd !== 12'd0) $display("[TB] FAIL reset_speeds got %0d/%0d required 0/0", lft_spd, rgt_spd);
    else nPass++;
    nChecks++;
    if (out_vld !== 1'b0 || out_vld3 !== 1'b0) $display("[TB] FAIL reset_vld got %b/%b required 0/0", out_vld, out_vld3);
    else nPass++;
    rst_n = 1'b1;
    @(negedge clk);
    nChecks++;
    if (lft3 !== 12'd0 || rgt3 !== 12'd0 || out_vld !== 1'b0) $display("[TB] FAIL post_reset got %0d/%0d vld=%b required 0/0 vld=0", lft3, rgt3, out_vld);
    else nPass++;
  endtask

  task automatic test_basic();
    int n;
    go = 1'b1;
    idle(1);
    driveSample(256);
    n = 0;
    while (!out_vld && n < 5) begin
      @(negedge clk);
      n++;
    end
    nChecks++;
    if (n !== 1) $display("[TB] FAIL basic_latency got %0d extra clocks required 1", n);
    else nPass++;
    nChecks++;
    if (s12(lft_spd) !== 451 || s12(rgt_spd) !== 573)
      $display("[TB] FAIL basic_speeds got lft=%0d rgt=%0d required lft=451 rgt=573", s12(lft_spd), s12(rgt_spd));
    else nPass++;
    idle(2);
  endtask

  task automatic test_saturation();
    clearAcc();
    driveSample('h7000);
    driveSample('h9000);
    driveSample('h8000);
    driveSample('h7FFF);
    driveSample(1024);
    driveSample(-1025);
    idle(4);
  endtask

  task automatic test_antiwindup();
    clearAcc();
    repeat (33) driveSample(1023);
    @(negedge clk);
    nChecks++;
    if (out_vld !== 1'b1 || s12(lft_spd) !== 1023 || s12(rgt_spd) !== 1)
      $display("[TB] FAIL antiwindup got vld=%b lft=%0d rgt=%0d required vld=1 lft=1023 rgt=1", out_vld, s12(lft_spd), s12(rgt_spd));
    else nPass++;
    nChecks++;
    if (s12(lft3) !== 1023 || s12(rgt3) !== 1)
      $display("[TB] FAIL antiwindup3 got lft=%0d rgt=%0d required lft=1023 rgt=1", s12(lft3), s12(rgt3));
    else nPass++;
    idle(3);
  endtask

  task automatic test_go_drop();
    driveSample(100);
    driveSample(-50);
    driveSample(300);
    driveSample(-400);
    driveSample(20);
    go = 1'b0;
    mAcc = 0;
    if (q2.size() > 0 && q2[q2.size()-1].cyc == cyc + 1) q2.delete(q2.size() - 1);
    if (q3.size() > 0 && q3[q3.size()-1].cyc == cyc + 1) q3.delete(q3.size() - 1);
    @(negedge clk);
    nChecks++;
    if (lft_spd !== 12'd0 || rgt_spd !== 12'd0 || out_vld !== 1'b0)
      $display("[TB] FAIL go_drop got lft=%0d rgt=%0d vld=%b required 0 0 0", lft_spd, rgt_spd, out_vld);
    else nPass++;
    nChecks++;
    if (lft3 !== 12'd0 || rgt3 !== 12'd0 || out_vld3 !== 1'b0)
      $display("[TB] FAIL go_drop3 got lft=%0d rgt=%0d vld=%b required 0 0 0", lft3, rgt3, out_vld3);
    else nPass++;
    go = 1'b1;
    driveSample(200);
    driveSample(-700);
    driveSample(50);
    idle(4);
  endtask

  task automatic test_vld_while_idle();
    go = 1'b0;
    mAcc = 0;
    driveSample(500);
    driveSample(-500);
    idle(2);
    go = 1'b1;
    driveSample(0);
    driveSample(10);
    idle(4);
  endtask

  task automatic test_depth3();
    int n;
    clearAcc();
    driveSample(100);
    idle(2);
    driveSample(200);
    idle(1);
    driveSample(300);
    idle(3);
    driveSample(400);
    n = 0;
    while (!out_vld3 && n < 5) begin
      @(negedge clk);
      n++;
    end
    nChecks++;
    if (n !== 1 || s12(lft3) !== 492 || s12(rgt3) !== 532)
      $display("[TB] FAIL depth3_gap got lft=%0d rgt=%0d wait=%0d required lft=492 rgt=532 wait=1", s12(lft3), s12(rgt3), n);
    else nPass++;
    nChecks++;
    if (s12(lft_spd) !== 492 || s12(rgt_spd) !== 532)
      $display("[TB] FAIL depth2_gap got lft=%0d rgt=%0d required lft=492 rgt=532", s12(lft_spd), s12(rgt_spd));
    else nPass++;
    idle(2);
  endtask

  task automatic test_back_to_back();
    frwrd_spd = 11'd1500; mFwd = 1500;
    for (int i = 0; i < 10; i++) driveSample(int'($urandom_range(0, 65535)));
    idle(3);
    frwrd_spd = 11'd0; mFwd = 0;
    for (int i = 0; i < 6; i++) driveSample(int'($urandom_range(0, 65535)));
    idle(4);
  endtask

  task automatic test_reset_mid();
    int n;
    frwrd_spd = 11'd700; mFwd = 700;
    driveSample(40);
    idle(3);
    driveSample(300);
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (lft_spd !== 12'd0 || rgt_spd !== 12'd0 || out_vld !== 1'b0)
      $display("[TB] FAIL reset_async got lft=%0d rgt=%0d vld=%b required 0 0 0", lft_spd, rgt_spd, out_vld);
    else nPass++;
    nChecks++;
    if (lft3 !== 12'd0 || rgt3 !== 12'd0 || out_vld3 !== 1'b0)
      $display("[TB] FAIL reset_async3 got lft=%0d rgt=%0d vld=%b required 0 0 0", lft3, rgt3, out_vld3);
    else nPass++;
    q2.delete();
    q3.delete();
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    driveSample(256);
    n = 0;
    while (!out_vld && n < 5) begin
      @(negedge clk);
      n++;
    end
    nChecks++;
    if (n !== 1 || s12(lft_spd) !== 639 || s12(rgt_spd) !== 761)
      $display("[TB] FAIL reset_resume got lft=%0d rgt=%0d wait=%0d required lft=639 rgt=761 wait=1", s12(lft_spd), s12(rgt_spd), n);
    else nPass++;
    idle(3);
  endtask

  // Hard stop in case the design never lets the sequence complete
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence followed by a drain check and the summary
  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_antiwindup();
    test_go_drop();
    test_vld_while_idle();
    test_depth3();
    test_back_to_back();
    test_reset_mid();
    idle(4);
    nChecks++;
    if (q2.size() !== 0 || q3.size() !== 0)
      $display("[TB] FAIL drain got %0d/%0d pending required 0/0", q2.size(), q3.size());
    else nPass++;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
